// File: rtl/alu_multicycle.sv
// Multi-cycle execute-stage ALU: single-cycle arithmetic/logic/compare ops,
// bit-serial shifts (one position per cycle), valid/ready on both sides.
module alu_multicycle #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_func,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            check,
  output logic            func_err
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_BGE  = 4'd10;
  localparam logic [3:0] OP_BGEU = 4'd11;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q;
  logic [3:0]      func_q;
  logic [4:0]      cnt_q;
  logic [4:0]      shamt;
  logic [XLEN-1:0] res_c;
  logic            chk_c;
  logic            err_c;
  logic            is_shift;
  logic            lt_s;
  logic            lt_u;

  assign shamt = in_b[4:0];
  assign lt_s  = $signed(in_a) < $signed(in_b);
  assign lt_u  = in_a < in_b;

  always_comb begin
    res_c    = '0;
    chk_c    = 1'b0;
    err_c    = 1'b0;
    is_shift = 1'b0;
    case (alu_func)
      OP_ADD:  res_c = in_a + in_b;
      OP_SUB: begin
        res_c = in_a - in_b;
        chk_c = (res_c == '0);
      end
      OP_XOR: begin
        res_c = in_a ^ in_b;
        chk_c = (res_c != '0);
      end
      OP_OR:   res_c = in_a | in_b;
      OP_AND:  res_c = in_a & in_b;
      OP_SLT: begin
        res_c = {{(XLEN-1){1'b0}}, lt_s};
        chk_c = lt_s;
      end
      OP_SLTU: begin
        res_c = {{(XLEN-1){1'b0}}, lt_u};
        chk_c = lt_u;
      end
      OP_BGE: begin
        res_c = {{(XLEN-1){1'b0}}, ~lt_s};
        chk_c = ~lt_s;
      end
      OP_BGEU: begin
        res_c = {{(XLEN-1){1'b0}}, ~lt_u};
        chk_c = ~lt_u;
      end
      // Zero-distance shifts finish immediately with the operand unchanged.
      OP_SLL, OP_SRL, OP_SRA: begin
        res_c    = in_a;
        is_shift = 1'b1;
      end
      default: err_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      func_q     <= '0;
      cnt_q      <= '0;
      alu_result <= '0;
      check      <= 1'b0;
      func_err   <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            func_q   <= alu_func;
            check    <= chk_c;
            func_err <= err_c;
            in_ready <= 1'b0;
            if (is_shift && (shamt != 5'd0)) begin
              alu_result <= in_a;
              cnt_q      <= shamt;
              state_q    <= StShift;
            end else begin
              alu_result <= res_c;
              state_q    <= StDone;
              out_valid  <= 1'b1;
            end
          end
        end
        StShift: begin
          case (func_q)
            OP_SLL:  alu_result <= {alu_result[XLEN-2:0], 1'b0};
            OP_SRL:  alu_result <= {1'b0, alu_result[XLEN-1:1]};
            default: alu_result <= {alu_result[XLEN-1], alu_result[XLEN-1:1]};
          endcase
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q   <= StDone;
            out_valid <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle.
module tb_alu_multicycle;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_BGE  = 4'd10;
  localparam logic [3:0] OP_BGEU = 4'd11;
  localparam logic [3:0] OP_EEE  = 4'd15;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_func;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic        check;
  logic        func_err;

  int tests = 0;
  int fails = 0;

  alu_multicycle #(.XLEN(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_func   (alu_func),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .check      (check),
    .func_err   (func_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op, wait (bounded) for out_valid, capture outputs, then drain it.
  task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic chk, output logic err,
                        output int lat);
    @(posedge clk); #1;
    in_valid = 1'b1; alu_func = f; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = alu_result; chk = check; err = func_err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r; logic c, e; int lat;
    tests++;
    if ({in_ready, out_valid, check, func_err} !== 4'b1000 || alu_result !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: rdy/vld/chk/err=%b res=%h, want 1000 res=0",
               {in_ready, out_valid, check, func_err}, alu_result);
    end
    // Start a long SRL, then reset part-way through.
    @(posedge clk); #1;
    in_valid = 1'b1; alu_func = OP_SRL; in_a = 32'hFFFF_0000; in_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({in_ready, out_valid, check, func_err} !== 4'b1000 || alu_result !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid_shift: rdy/vld/chk/err=%b res=%h, want 1000 res=0",
               {in_ready, out_valid, check, func_err}, alu_result);
    end
    #2 reset_n = 1'b1;
    run_op(OP_ADD, 32'd7, 32'd9, r, c, e, lat);
    tests++;
    if (r !== 32'd16 || lat !== 1) begin
      fails++;
      $display("FAIL add_after_reset: res=%0d lat=%0d, want 16 lat 1", r, lat);
    end
  endtask

  task automatic test_single_cycle();
    logic [31:0] r; logic c, e; int lat;
    run_op(OP_SUB, 32'd5, 32'd5, r, c, e, lat);
    tests++;
    if (r !== 32'd0 || c !== 1'b1 || lat !== 1) begin
      fails++; $display("FAIL sub_eq: res=%h chk=%b lat=%0d, want 0 1 1", r, c, lat);
    end
    run_op(OP_SUB, 32'd3, 32'd5, r, c, e, lat);
    tests++;
    if (r !== 32'hFFFF_FFFE || c !== 1'b0) begin
      fails++; $display("FAIL sub_wrap: res=%h chk=%b, want fffffffe 0", r, c);
    end
    run_op(OP_XOR, 32'd3, 32'd3, r, c, e, lat);
    tests++;
    if (r !== 32'd0 || c !== 1'b0) begin
      fails++; $display("FAIL xor_eq: res=%h chk=%b, want 0 0", r, c);
    end
    run_op(OP_XOR, 32'd3, 32'd5, r, c, e, lat);
    tests++;
    if (r !== 32'd6 || c !== 1'b1) begin
      fails++; $display("FAIL xor_ne: res=%h chk=%b, want 6 1", r, c);
    end
    run_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, r, c, e, lat);
    tests++;
    if (r !== 32'd1 || c !== 1'b1) begin
      fails++; $display("FAIL slt: res=%h chk=%b, want 1 1", r, c);
    end
    run_op(OP_SLTU, 32'hFFFF_FFFF, 32'd1, r, c, e, lat);
    tests++;
    if (r !== 32'd0 || c !== 1'b0) begin
      fails++; $display("FAIL sltu: res=%h chk=%b, want 0 0", r, c);
    end
  endtask

  task automatic test_shift();
    logic [31:0] r; logic c, e; int lat;
    run_op(OP_SRA, 32'h8000_0000, 32'd31, r, c, e, lat);
    tests++;
    if (r !== 32'hFFFF_FFFF || lat !== 32 || c !== 1'b0) begin
      fails++; $display("FAIL sra31: res=%h lat=%0d chk=%b, want ffffffff 32 0", r, lat, c);
    end
    run_op(OP_SLL, 32'd1, 32'd0, r, c, e, lat);
    tests++;
    if (r !== 32'd1 || lat !== 1) begin
      fails++; $display("FAIL sll0: res=%h lat=%0d, want 1 1", r, lat);
    end
    run_op(OP_SLL, 32'd1, 32'd4, r, c, e, lat);
    tests++;
    if (r !== 32'd16 || lat !== 5) begin
      fails++; $display("FAIL sll4: res=%h lat=%0d, want 10 5", r, lat);
    end
    run_op(OP_SRL, 32'h8000_0000, 32'd3, r, c, e, lat);
    tests++;
    if (r !== 32'h1000_0000 || lat !== 4) begin
      fails++; $display("FAIL srl3: res=%h lat=%0d, want 10000000 4", r, lat);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; alu_func = OP_ADD; in_a = 32'd1; in_b = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; alu_func = OP_SUB; in_a = 32'd100; in_b = 32'd1;
      @(negedge clk);
      if (out_valid !== 1'b1 || alu_result !== 32'd2 || in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tests++;
    if (bad !== 0) begin
      fails++; $display("FAIL backpressure_hold: %0d bad cycles, want 0", bad);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_result !== 32'd2) begin
      fails++;
      $display("FAIL backpressure_release: rdy=%b vld=%b res=%h, want 1 0 2",
               in_ready, out_valid, alu_result);
    end
  endtask

  task automatic test_branch();
    logic [31:0] r; logic c, e; int lat;
    run_op(OP_BGE, 32'hFFFF_FFFF, 32'd1, r, c, e, lat);
    tests++;
    if (c !== 1'b0 || r !== 32'd0) begin
      fails++; $display("FAIL bge_neg: chk=%b res=%h, want 0 0", c, r);
    end
    run_op(OP_BGEU, 32'hFFFF_FFFF, 32'd1, r, c, e, lat);
    tests++;
    if (c !== 1'b1 || r !== 32'd1) begin
      fails++; $display("FAIL bgeu_big: chk=%b res=%h, want 1 1", c, r);
    end
    run_op(OP_BGE, 32'd42, 32'd42, r, c, e, lat);
    tests++;
    if (c !== 1'b1) begin
      fails++; $display("FAIL bge_eq: chk=%b, want 1", c);
    end
    run_op(OP_BGEU, 32'd42, 32'd42, r, c, e, lat);
    tests++;
    if (c !== 1'b1) begin
      fails++; $display("FAIL bgeu_eq: chk=%b, want 1", c);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] r; logic c, e; int lat;
    run_op(OP_ADD, 32'd3, 32'd4, r, c, e, lat);
    run_op(OP_EEE, 32'd3, 32'd4, r, c, e, lat);
    tests++;
    if (r !== 32'd0 || e !== 1'b1 || c !== 1'b0 || lat !== 1) begin
      fails++;
      $display("FAIL illegal: res=%h err=%b chk=%b lat=%0d, want 0 1 0 1", r, e, c, lat);
    end
    run_op(OP_ADD, 32'd3, 32'd4, r, c, e, lat);
    tests++;
    if (e !== 1'b0 || r !== 32'd7) begin
      fails++; $display("FAIL illegal_clear: err=%b res=%h, want 0 7", e, r);
    end
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_func = '0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    test_reset();
    test_single_cycle();
    test_shift();
    test_backpressure();
    test_branch();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
